// File: rtl/ds_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ds_pkg
//  Brief    : Shared constants and state encoding for the DownSampler datapath
//             (block sampler -> block decimator -> sink).
//  Revision : 1.0  initial release
// ============================================================================
package ds_pkg;

    // Words per parallel block, also used by the upstream sampler
    localparam int DS_BLOCK_WORDS = 8;
    localparam int DS_IDX_W       = 3;

    // Headroom bits so that the sum of a full block never overflows
    localparam int DS_ACC_GUARD   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } ds_state_e;

    // Exact log2 for the supported power-of-two decimation factors
    function automatic int ds_log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) == v) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage : ds_pkg
`default_nettype wire

// File: rtl/ds_group_acc.sv
`default_nettype none
// ============================================================================
//  Module   : ds_group_acc
//  Brief    : Extends one block word, adds it to the running group sum and
//             produces the group average (sum >> log2(DECIM)).
//  Revision : 1.0  initial release
// ============================================================================
module ds_group_acc
    import ds_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DECIM  = 2,
    parameter int SIGNED = 0
) (
    input  logic [DATA_W+DS_ACC_GUARD-1:0] acc_i,
    input  logic [DATA_W-1:0]              word_i,
    output logic [DATA_W+DS_ACC_GUARD-1:0] sum_o,
    output logic [DATA_W-1:0]              avg_o
);

    localparam int c_ACC_W = DATA_W + DS_ACC_GUARD;
    localparam int c_SHIFT = ds_log2(DECIM);

    logic [c_ACC_W-1:0] w_ext;

    generate
        if (SIGNED != 0) begin : g_sext
            assign w_ext = {{DS_ACC_GUARD{word_i[DATA_W-1]}}, word_i};
        end else begin : g_zext
            assign w_ext = {{DS_ACC_GUARD{1'b0}}, word_i};
        end
    endgenerate

    assign sum_o = acc_i + w_ext;

    // Signed mode rounds toward -inf via arithmetic shift
    generate
        if (SIGNED != 0) begin : g_ashift
            assign avg_o = DATA_W'($signed(sum_o) >>> c_SHIFT);
        end else begin : g_lshift
            assign avg_o = DATA_W'(sum_o >> c_SHIFT);
        end
    endgenerate

endmodule : ds_group_acc
`default_nettype wire

// File: rtl/axis_block_decimator.sv
`default_nettype none
// ============================================================================
//  Module   : axis_block_decimator
//  Brief    : Accepts one 8-word parallel block, averages each group of DECIM
//             consecutive words and emits 8/DECIM samples as a serial
//             AXI4-Stream with tlast on the final sample of the block.
//  Revision : 1.0  initial release
// ============================================================================
module axis_block_decimator
    import ds_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DECIM  = 2,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_axis_tdata0,
    input  logic [DATA_W-1:0] s_axis_tdata1,
    input  logic [DATA_W-1:0] s_axis_tdata2,
    input  logic [DATA_W-1:0] s_axis_tdata3,
    input  logic [DATA_W-1:0] s_axis_tdata4,
    input  logic [DATA_W-1:0] s_axis_tdata5,
    input  logic [DATA_W-1:0] s_axis_tdata6,
    input  logic [DATA_W-1:0] s_axis_tdata7,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    localparam int                c_ACC_W     = DATA_W + DS_ACC_GUARD;
    localparam logic [DS_IDX_W-1:0] c_GRP_MASK  = DS_IDX_W'(DECIM - 1);
    localparam logic [DS_IDX_W-1:0] c_LAST_IDX  = DS_IDX_W'(DS_BLOCK_WORDS - 1);

    generate
        if (!(DECIM == 1 || DECIM == 2 || DECIM == 4 || DECIM == 8)) begin : g_bad_decim
            $error("axis_block_decimator: DECIM must be 1, 2, 4 or 8");
        end
    endgenerate

    ds_state_e            state_q, state_d;
    logic [DS_IDX_W-1:0]  idx_q, idx_d;
    logic [c_ACC_W-1:0]   acc_q, acc_d;
    logic                 s_ready_q, s_ready_d;
    logic                 m_valid_q, m_valid_d;
    logic                 m_last_q, m_last_d;
    logic [DATA_W-1:0]    m_data_q, m_data_d;
    logic [DATA_W-1:0]    blk_q [DS_BLOCK_WORDS];
    logic [DATA_W-1:0]    w_in  [DS_BLOCK_WORDS];
    logic                 w_blk_load;
    logic [DATA_W-1:0]    w_word;
    logic [c_ACC_W-1:0]   w_sum;
    logic [DATA_W-1:0]    w_avg;
    logic                 w_grp_last;
    logic                 w_word_last;

    assign w_in[0] = s_axis_tdata0;
    assign w_in[1] = s_axis_tdata1;
    assign w_in[2] = s_axis_tdata2;
    assign w_in[3] = s_axis_tdata3;
    assign w_in[4] = s_axis_tdata4;
    assign w_in[5] = s_axis_tdata5;
    assign w_in[6] = s_axis_tdata6;
    assign w_in[7] = s_axis_tdata7;

    assign w_word      = blk_q[idx_q];
    assign w_grp_last  = ((idx_q & c_GRP_MASK) == c_GRP_MASK);
    assign w_word_last = (idx_q == c_LAST_IDX);

    ds_group_acc #(
        .DATA_W (DATA_W),
        .DECIM  (DECIM),
        .SIGNED (SIGNED)
    ) u_group_acc (
        .acc_i  (acc_q),
        .word_i (w_word),
        .sum_o  (w_sum),
        .avg_o  (w_avg)
    );

    // Block register: captured only on the accept handshake, so later input
    // changes or extra tvalid pulses cannot disturb the block being reduced
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DS_BLOCK_WORDS; i++) begin
                blk_q[i] <= '0;
            end
        end else if (w_blk_load) begin
            for (int i = 0; i < DS_BLOCK_WORDS; i++) begin
                blk_q[i] <= w_in[i];
            end
        end
    end

    // State and registered-output update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        s_ready_d  = s_ready_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        m_data_d   = m_data_q;
        w_blk_load = 1'b0;

        case (state_q)
            IDLE: begin
                s_ready_d = 1'b1;
                if (s_ready_q && s_axis_tvalid) begin
                    w_blk_load = 1'b1;
                    idx_d      = '0;
                    acc_d      = '0;
                    s_ready_d  = 1'b0;
                    state_d    = ACCUM;
                end
            end
            ACCUM: begin
                idx_d = idx_q + 1'b1;
                if (w_grp_last) begin
                    acc_d     = '0;
                    m_data_d  = w_avg;
                    m_valid_d = 1'b1;
                    m_last_d  = w_word_last;
                    state_d   = OUT;
                end else begin
                    acc_d = w_sum;
                end
            end
            OUT: begin
                // tvalid is always high in this state, so tready alone completes the handshake
                if (m_axis_tready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (m_last_q) begin
                        s_ready_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d   = ACCUM;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tdata  = m_data_q;

endmodule : axis_block_decimator
`default_nettype wire

// File: tb/tb_axis_block_decimator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_block_decimator
//  Brief    : Directed self-checking bench; three decimator instances
//             (DECIM=2 unsigned, DECIM=8 unsigned, DECIM=2 signed) share
//             data, tready and reset, each with its own s_axis_tvalid.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_block_decimator;

    typedef logic [31:0] blk_t [8];

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_d [8];
    logic [2:0]  s_valid;
    logic [2:0]  s_ready;
    logic [2:0]  m_valid;
    logic [2:0]  m_last;
    logic        m_ready;
    logic [31:0] m_data [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axis_block_decimator #(.DATA_W(32), .DECIM(2), .SIGNED(0)) u_dut_d2 (
        .clk(clk), .reset(rst),
        .s_axis_tdata0(s_d[0]), .s_axis_tdata1(s_d[1]), .s_axis_tdata2(s_d[2]), .s_axis_tdata3(s_d[3]),
        .s_axis_tdata4(s_d[4]), .s_axis_tdata5(s_d[5]), .s_axis_tdata6(s_d[6]), .s_axis_tdata7(s_d[7]),
        .s_axis_tvalid(s_valid[0]), .s_axis_tready(s_ready[0]),
        .m_axis_tdata(m_data[0]), .m_axis_tvalid(m_valid[0]),
        .m_axis_tready(m_ready), .m_axis_tlast(m_last[0])
    );

    axis_block_decimator #(.DATA_W(32), .DECIM(8), .SIGNED(0)) u_dut_d8 (
        .clk(clk), .reset(rst),
        .s_axis_tdata0(s_d[0]), .s_axis_tdata1(s_d[1]), .s_axis_tdata2(s_d[2]), .s_axis_tdata3(s_d[3]),
        .s_axis_tdata4(s_d[4]), .s_axis_tdata5(s_d[5]), .s_axis_tdata6(s_d[6]), .s_axis_tdata7(s_d[7]),
        .s_axis_tvalid(s_valid[1]), .s_axis_tready(s_ready[1]),
        .m_axis_tdata(m_data[1]), .m_axis_tvalid(m_valid[1]),
        .m_axis_tready(m_ready), .m_axis_tlast(m_last[1])
    );

    axis_block_decimator #(.DATA_W(32), .DECIM(2), .SIGNED(1)) u_dut_s2 (
        .clk(clk), .reset(rst),
        .s_axis_tdata0(s_d[0]), .s_axis_tdata1(s_d[1]), .s_axis_tdata2(s_d[2]), .s_axis_tdata3(s_d[3]),
        .s_axis_tdata4(s_d[4]), .s_axis_tdata5(s_d[5]), .s_axis_tdata6(s_d[6]), .s_axis_tdata7(s_d[7]),
        .s_axis_tvalid(s_valid[2]), .s_axis_tready(s_ready[2]),
        .m_axis_tdata(m_data[2]), .m_axis_tvalid(m_valid[2]),
        .m_axis_tready(m_ready), .m_axis_tlast(m_last[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Raise tvalid on instance d and wait (bounded) for the accept edge
    task automatic do_accept(input int d, input bit keep, input string tag);
        int n;
        n = 0;
        s_valid[d] = 1'b1;
        while (n < 64) begin
            @(negedge clk);
            if (s_ready[d]) break;
            n++;
        end
        chk({tag, ".accept"}, {31'd0, s_ready[d]}, 32'd1);
        @(posedge clk);
        #1;
        if (!keep) s_valid[d] = 1'b0;
    endtask

    // Wait for one output sample, optionally stall it, then complete the handshake
    task automatic get_sample(input int d, input int stall, input logic [31:0] exp_d,
                              input bit exp_l, input int exp_lat, input string tag);
        int n;
        n = 0;
        m_ready = (stall == 0);
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!m_valid[d] && n < 64);
        chk({tag, ".lat"},  n, exp_lat);
        chk({tag, ".data"}, m_data[d], exp_d);
        chk({tag, ".last"}, {31'd0, m_last[d]}, {31'd0, exp_l});
        chk({tag, ".srdy"}, {31'd0, s_ready[d]}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s.hold%0d.data", tag, i), m_data[d], exp_d);
            chk($sformatf("%s.hold%0d.vl", tag, i), {30'd0, m_valid[d], m_last[d]},
                {30'd0, 1'b1, exp_l});
            chk($sformatf("%s.hold%0d.srdy", tag, i), {31'd0, s_ready[d]}, 32'd0);
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".drop"}, {31'd0, m_valid[d]}, 32'd0);
    endtask

    task automatic run_block(input int d, input blk_t w, input blk_t e, input int ns,
                             input int lat, input int stall_idx, input string tag);
        for (int i = 0; i < 8; i++) s_d[i] = w[i];
        do_accept(d, 1'b0, tag);
        for (int s = 0; s < ns; s++) begin
            get_sample(d, (s == stall_idx) ? 5 : 0, e[s], (s == ns - 1), lat,
                       $sformatf("%s.s%0d", tag, s));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        blk_t w;
        blk_t e;
        int   seen;

        rst     = 1'b1;
        s_valid = 3'b000;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) s_d[i] = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst%0d.flags", d), {29'd0, s_ready[d], m_valid[d], m_last[d]}, 32'd0);
            chk($sformatf("rst%0d.data", d), m_data[d], 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        chk("rel.srdy_before", {29'd0, s_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rel.srdy_after", {29'd0, s_ready}, 32'd7);

        // 1: DECIM=2 basic averaging
        w = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        e = '{32'd1, 32'd3, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0};
        run_block(0, w, e, 4, 2, -1, "t1");

        // 2: DECIM=8 full-scale words, no wrap
        w = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        e = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        run_block(1, w, e, 1, 8, -1, "t2");

        // 3: signed, -1 + -2 = -3 >>> 1 = -2
        w = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        e = '{32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        run_block(2, w, e, 4, 2, -1, "t3");

        // 4: backpressure on the second sample
        w = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80};
        e = '{32'd15, 32'd35, 32'd55, 32'd75, 32'd0, 32'd0, 32'd0, 32'd0};
        run_block(0, w, e, 4, 2, 1, "t4");

        // 5: next block held valid (with changed data) during output
        w = '{32'd2, 32'd4, 32'd6, 32'd8, 32'd10, 32'd12, 32'd14, 32'd16};
        for (int i = 0; i < 8; i++) s_d[i] = w[i];
        do_accept(0, 1'b1, "t5a");
        w = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0002,
              32'd0, 32'd1, 32'd7, 32'd9};
        for (int i = 0; i < 8; i++) s_d[i] = w[i];
        e = '{32'd3, 32'd7, 32'd11, 32'd15, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int s = 0; s < 4; s++) get_sample(0, 0, e[s], (s == 3), 2, $sformatf("t5a.s%0d", s));
        chk("t5.srdy_after_last", {31'd0, s_ready[0]}, 32'd1);
        @(posedge clk);
        #1;
        s_valid[0] = 1'b0;
        chk("t5.accepted", {31'd0, s_ready[0]}, 32'd0);
        e = '{32'hFFFF_FFFF, 32'h8000_0001, 32'd0, 32'd8, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int s = 0; s < 4; s++) get_sample(0, 0, e[s], (s == 3), 2, $sformatf("t5b.s%0d", s));

        // 6: reset during accumulation of the third sample
        w = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        for (int i = 0; i < 8; i++) s_d[i] = w[i];
        do_accept(0, 1'b0, "t6");
        get_sample(0, 0, 32'd1, 1'b0, 2, "t6.s0");
        get_sample(0, 0, 32'd3, 1'b0, 2, "t6.s1");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6.rst.flags", {29'd0, s_ready[0], m_valid[0], m_last[0]}, 32'd0);
        chk("t6.rst.data", m_data[0], 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (m_valid[0]) seen++;
        end
        chk("t6.no_partial", seen, 0);
        w = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd4, 32'd4, 32'd6, 32'd8};
        e = '{32'd0, 32'h8000_0000, 32'd4, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0};
        run_block(0, w, e, 4, 2, -1, "t6r");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_axis_block_decimator
`default_nettype wire
